// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t   : FSM state encoding (IDLE / BUSY / DONE; 2'd3 is unused)
//   CNT_W     : width of the wait-cycle counter (LATENCY up to 15)
//   addr_bad  : address check shared with the instruction-memory responder
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // True when a byte address is not word aligned or falls beyond the array.
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input int unsigned depth_words);
    logic [31:0] word;
    word = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array backing the data-memory responder.
// Synchronous write, registered read with a read enable so the output holds
// between accesses. rzero loads 0 instead of the array word (failed checks).
//   clk, rst      : clock, asynchronous active-high reset (read register only)
//   we, re, rzero : write enable, read-register load enable, load-zero select
//   idx           : word index shared by read and write
//   wdata, rdata  : write data, registered read data
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic          rzero,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Left unreset so it maps onto block RAM and survives rst.
  logic [31:0] mem [0:DEPTH_WORDS-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rzero ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the datapath load/store port. Serves word
// accesses after LATENCY wait cycles and holds the datapath with a
// combinational Stall until each access completes.
//   clk, rst   : clock, asynchronous active-high reset
//   MemRead    : load request, held until Ready
//   MemWrite   : store request, held until Ready
//   Addr       : byte address
//   WriteData  : store data
//   ReadData   : registered load data, valid with Ready
//   Ready      : registered one-cycle completion pulse
//   Error      : registered; bad address at completion, or both strobes in IDLE
//   Stall      : combinational hold request to PC / register-file write
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Error,
  output logic        Stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_store;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;

  logic req, both, in_idle, in_busy, complete;
  logic cur_store, bad, mem_we, mem_re;
  logic [31:0] cur_addr, cur_wdata;

  assign req     = MemRead ^ MemWrite;
  assign both    = MemRead & MemWrite;
  assign in_idle = (state == S_IDLE);
  assign in_busy = (state == S_BUSY);

  // Edge entering DONE. With LATENCY=0 this happens straight from IDLE, so
  // the access must use the live inputs rather than the latched copy.
  assign complete = (in_idle & req & (LATENCY == 0)) | (in_busy & (cnt == '0));

  assign cur_store = in_idle ? MemWrite  : lat_store;
  assign cur_addr  = in_idle ? Addr      : lat_addr;
  assign cur_wdata = in_idle ? WriteData : lat_wdata;
  assign bad       = addr_bad(cur_addr, DEPTH_WORDS);

  // Store commits and read data loads on the edge entering DONE. A failed
  // check suppresses the store and forces ReadData to 0 for either op.
  assign mem_we = complete & cur_store & ~bad & ~rst;
  assign mem_re = complete & (~cur_store | bad);

  assign Stall = ~rst & ((in_idle & (MemRead | MemWrite)) | in_busy);

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .rzero (bad),
    .idx   (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (ReadData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_store <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      Ready     <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Ready <= 1'b0;
      Error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (both) begin
            Error <= 1'b1;
          end else if (req) begin
            lat_store <= MemWrite;
            lat_addr  <= Addr;
            lat_wdata <= WriteData;
            if (LATENCY == 0) begin
              state <= S_DONE;
              Ready <= 1'b1;
              Error <= bad;
            end else begin
              state <= S_BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state <= S_DONE;
            Ready <= 1'b1;
            Error <= bad;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // DONE ignores the still-held request (same instruction); the
        // unused encoding also recovers to IDLE.
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance checked every cycle against
// a transaction-level model, plus a LATENCY=0 instance with directed checks.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd_a = 1'b0, wr_a = 1'b0;
  logic [31:0] addr_a = '0, wd_a = '0;
  logic [31:0] rdata_a;
  logic        ready_a, err_a, stall_a;

  logic        rd_b = 1'b0, wr_b = 1'b0;
  logic [31:0] addr_b = '0, wd_b = '0;
  logic [31:0] rdata_b;
  logic        ready_b, err_b, stall_b;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut_a (
    .clk(clk), .rst(rst), .MemRead(rd_a), .MemWrite(wr_a), .Addr(addr_a),
    .WriteData(wd_a), .ReadData(rdata_a), .Ready(ready_a), .Error(err_a),
    .Stall(stall_a)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .MemRead(rd_b), .MemWrite(wr_b), .Addr(addr_b),
    .WriteData(wd_b), .ReadData(rdata_b), .Ready(ready_b), .Error(err_b),
    .Stall(stall_b)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model of the LATENCY=2 instance ----------------
  // A request seen in IDLE completes LAT+1 cycles later; the outputs in
  // that cycle follow from the address rules and the model memory.
  logic [31:0] model_mem [0:DEPTH-1];
  bit          pending = 1'b0;
  bit          proto_d = 1'b0;
  int          t_issue = 0;
  logic        p_store = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0, last_rd = '0;

  always @(negedge clk) begin
    logic        e_ready, e_err, e_stall, proto_n, bad;
    logic [31:0] e_rd;
    if (rst) begin
      pending = 1'b0;
      proto_d = 1'b0;
      last_rd = '0;
      chk("model_rst_ready", {31'b0, ready_a}, 32'd0);
      chk("model_rst_error", {31'b0, err_a}, 32'd0);
      chk("model_rst_stall", {31'b0, stall_a}, 32'd0);
      chk("model_rst_rdata", rdata_a, 32'd0);
    end else begin
      e_ready = 1'b0;
      e_err   = proto_d;
      e_stall = 1'b0;
      e_rd    = last_rd;
      proto_n = 1'b0;
      if (pending && cyc == t_issue + LAT + 1) begin
        bad     = (p_addr % 4 != 0) || (p_addr >= 32'(4 * DEPTH));
        e_ready = 1'b1;
        e_err   = bad;
        if (bad)           e_rd = '0;
        else if (!p_store) e_rd = model_mem[p_addr / 4];
        else               model_mem[p_addr / 4] = p_wdata;
        pending = 1'b0;
      end else if (pending) begin
        e_stall = 1'b1;
      end else if (rd_a || wr_a) begin
        e_stall = 1'b1;
        if (rd_a && wr_a) begin
          proto_n = 1'b1;
        end else begin
          pending = 1'b1;
          t_issue = cyc;
          p_store = wr_a;
          p_addr  = addr_a;
          p_wdata = wd_a;
        end
      end
      last_rd = e_rd;
      proto_d = proto_n;
      chk("model_ready", {31'b0, ready_a}, {31'b0, e_ready});
      chk("model_error", {31'b0, err_a}, {31'b0, e_err});
      chk("model_stall", {31'b0, stall_a}, {31'b0, e_stall});
      chk("model_rdata", rdata_a, e_rd);
    end
  end

  // ---------------- drivers ----------------
  task automatic access_a(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic er, output int stalls, output int cycles);
    bit done;
    done = 1'b0; rd = '0; er = 1'b0; stalls = 0; cycles = 0;
    @(posedge clk); #1;
    rd_a = r; wr_a = w; addr_a = a; wd_a = d;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      cycles++;
      if (stall_a) stalls++;
      if (ready_a) begin
        done = 1'b1; rd = rdata_a; er = err_a;
      end
    end
    chk("a_access_completed", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    rd_a = 1'b0; wr_a = 1'b0;
    $display("A %s addr=%h wdata=%h -> rdata=%h err=%0b stalls=%0d cycles=%0d",
             w ? "ST" : "LD", a, d, rd, er, stalls, cycles);
  endtask

  task automatic access_b(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic er, output int stalls, output int cycles);
    bit done;
    done = 1'b0; rd = '0; er = 1'b0; stalls = 0; cycles = 0;
    @(posedge clk); #1;
    rd_b = r; wr_b = w; addr_b = a; wd_b = d;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      cycles++;
      if (stall_b) stalls++;
      if (ready_b) begin
        done = 1'b1; rd = rdata_b; er = err_b;
      end
    end
    chk("b_access_completed", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    rd_b = 1'b0; wr_b = 1'b0;
    $display("B %s addr=%h wdata=%h -> rdata=%h err=%0b stalls=%0d cycles=%0d",
             w ? "ST" : "LD", a, d, rd, er, stalls, cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          st, cy;

    for (int i = 0; i < DEPTH; i++) begin
      dut_a.u_array.mem[i] = '0;
      dut_b.u_array.mem[i] = '0;
      model_mem[i]         = '0;
    end
    dut_a.u_array.mem[64] = 32'hDEADBEEF; model_mem[64] = 32'hDEADBEEF;
    dut_a.u_array.mem[66] = 32'hF0F0F0F0; model_mem[66] = 32'hF0F0F0F0;
    dut_b.u_array.mem[0]  = 32'h00000100;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_b", {31'b0, ready_b}, 32'd0);
    chk("reset_error_b", {31'b0, err_b}, 32'd0);
    chk("reset_rdata_b", rdata_b, 32'd0);
    chk("reset_stall_b", {31'b0, stall_b}, 32'd0);

    // Preloaded load with LATENCY=2.
    access_a(1'b1, 1'b0, 32'h100, 32'h0, rd, er, st, cy);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_error", {31'b0, er}, 32'd0);
    chk("t1_stall_cycles", st, 32'd3);
    chk("t1_req_to_ready", cy, 32'd4);

    // Store then load back.
    access_a(1'b0, 1'b1, 32'h104, 32'hCAFEF00D, rd, er, st, cy);
    chk("t2_store_error", {31'b0, er}, 32'd0);
    chk("t2_mem65", dut_a.u_array.mem[65], 32'hCAFEF00D);
    chk("t2_model_mem65", model_mem[65], 32'hCAFEF00D);
    chk("t2_rdata_held", rd, 32'hDEADBEEF);
    access_a(1'b1, 1'b0, 32'h104, 32'h0, rd, er, st, cy);
    chk("t2_load_back", rd, 32'hCAFEF00D);

    // Misaligned and out-of-range stores, misaligned load.
    access_a(1'b0, 1'b1, 32'h102, 32'h11111111, rd, er, st, cy);
    chk("t4_misaligned_error", {31'b0, er}, 32'd1);
    chk("t4_misaligned_rdata", rd, 32'd0);
    chk("t4_mem64_kept", dut_a.u_array.mem[64], 32'hDEADBEEF);
    access_a(1'b0, 1'b1, 32'h400, 32'h22222222, rd, er, st, cy);
    chk("t4_range_error", {31'b0, er}, 32'd1);
    chk("t4_range_rdata", rd, 32'd0);
    chk("t4_mem0_kept", dut_a.u_array.mem[0], 32'd0);
    access_a(1'b1, 1'b0, 32'h101, 32'h0, rd, er, st, cy);
    chk("t4_load_misaligned_error", {31'b0, er}, 32'd1);
    chk("t4_load_misaligned_rdata", rd, 32'd0);
    access_a(1'b1, 1'b0, 32'h100, 32'h0, rd, er, st, cy);
    chk("t4_reload", rd, 32'hDEADBEEF);

    // Reset in the middle of a store.
    @(posedge clk); #1;
    wr_a = 1'b1; addr_a = 32'h108; wd_a = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_stall_in_rst", {31'b0, stall_a}, 32'd0);
    chk("t5_ready_in_rst", {31'b0, ready_a}, 32'd0);
    chk("t5_error_in_rst", {31'b0, err_a}, 32'd0);
    chk("t5_rdata_in_rst", rdata_a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; wr_a = 1'b0;
    repeat (4) @(posedge clk);
    chk("t5_mem66_kept", dut_a.u_array.mem[66], 32'hF0F0F0F0);
    $display("A RST mid-busy ST addr=00000108 -> mem66=%h", dut_a.u_array.mem[66]);

    // Both strobes together.
    @(posedge clk); #1;
    rd_a = 1'b1; wr_a = 1'b1; addr_a = 32'h100; wd_a = 32'hBAD0BAD0;
    @(negedge clk);
    chk("t6_stall", {31'b0, stall_a}, 32'd1);
    @(posedge clk); #1;
    rd_a = 1'b0; wr_a = 1'b0;
    @(negedge clk);
    chk("t6_error_pulse", {31'b0, err_a}, 32'd1);
    chk("t6_no_ready", {31'b0, ready_a}, 32'd0);
    @(negedge clk);
    chk("t6_error_cleared", {31'b0, err_a}, 32'd0);
    chk("t6_mem64_kept", dut_a.u_array.mem[64], 32'hDEADBEEF);
    $display("A PROTO both strobes -> error pulse seen");
    access_a(1'b1, 1'b0, 32'h100, 32'h0, rd, er, st, cy);
    chk("t6_idle_after", st, 32'd3);

    // LATENCY=0 instance.
    access_b(1'b1, 1'b0, 32'h0, 32'h0, rd, er, st, cy);
    chk("t3_rdata", rd, 32'h00000100);
    chk("t3_error", {31'b0, er}, 32'd0);
    chk("t3_stall_cycles", st, 32'd1);
    chk("t3_req_to_ready", cy, 32'd2);
    access_b(1'b0, 1'b1, 32'h4, 32'hAAAA5555, rd, er, st, cy);
    chk("t3_store_mem1", dut_b.u_array.mem[1], 32'hAAAA5555);
    access_b(1'b1, 1'b0, 32'h4, 32'h0, rd, er, st, cy);
    chk("t3_load_back", rd, 32'hAAAA5555);
    access_b(1'b0, 1'b1, 32'h3FE, 32'h5, rd, er, st, cy);
    chk("t3_misaligned_error", {31'b0, er}, 32'd1);
    chk("t3_misaligned_rdata", rd, 32'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
